// File: rtl/hop_input_ctrl.sv
// Keyboard front end: decodes USB keycode slots into a FWFT queue of hop commands with auto-repeat.
// Press reaches hop_valid 2 cycles after keycode; a full queue refuses new events (sticky overflow) unless popping.
module hop_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  input  logic         pop_rdy
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         empty;
  logic         full;
  logic         do_push;
  logic         do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = !empty && pop_rdy;
  // a pop in the same cycle frees the slot the push needs
  assign push_rdy = !full || do_pop;
  assign do_push  = push_vld && push_rdy;
  assign pop_vld  = !empty;
  assign pop_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module hop_input_ctrl #(
  parameter int         NUM_SLOTS    = 2,
  parameter logic [7:0] KEY_UP       = 8'h52,
  parameter logic [7:0] KEY_DOWN     = 8'h51,
  parameter logic [7:0] KEY_LEFT     = 8'h50,
  parameter logic [7:0] KEY_RIGHT    = 8'h4F,
  parameter bit         REPEAT_EN    = 1'b1,
  parameter int         REPEAT_DELAY = 15,
  parameter int         REPEAT_RATE  = 6,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [8*NUM_SLOTS-1:0] keycode,
  input  logic                   frame_clk,
  input  logic                   hop_ready,
  output logic                   hop_valid,
  output logic [1:0]             hop_dir,
  output logic [3:0]             held,
  output logic [3:0]             last_dir,
  output logic                   overflow
);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DELAY_LD = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RATE_LD  = CW'(REPEAT_RATE);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t        state, state_nxt;
  logic [1:0]    act_dir, act_nxt;
  logic [CW-1:0] rpt_cnt, cnt_nxt;
  logic [3:0]    held_raw;
  logic [3:0]    held_q;
  logic [3:0]    press;
  logic          press_any;
  logic [1:0]    press_dir;
  logic [7:0]    slot;
  logic          fs1, fs2, fs3;
  logic          frame_tick;
  logic          rpt_vld;
  logic          enq_vld;
  logic [1:0]    enq_dat;
  logic          enq_rdy;

  always_comb begin
    held_raw = '0;
    slot     = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot = keycode[8*k +: 8];
      if (slot == KEY_UP)    held_raw[0] = 1'b1;
      if (slot == KEY_DOWN)  held_raw[1] = 1'b1;
      if (slot == KEY_LEFT)  held_raw[2] = 1'b1;
      if (slot == KEY_RIGHT) held_raw[3] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      held   <= '0;
      held_q <= '0;
      fs1    <= 1'b0;
      fs2    <= 1'b0;
      fs3    <= 1'b0;
    end else begin
      held   <= held_raw;
      held_q <= held;
      fs1    <= frame_clk;
      fs2    <= fs1;
      fs3    <= fs2;
    end
  end

  assign frame_tick = fs2 & ~fs3;
  assign press      = held & ~held_q;
  assign press_any  = |press;

  // simultaneous presses collapse to one hop: up > down > left > right
  always_comb begin
    press_dir = 2'd3;
    if (press[0])      press_dir = 2'd0;
    else if (press[1]) press_dir = 2'd1;
    else if (press[2]) press_dir = 2'd2;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      act_dir <= '0;
      rpt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      act_dir <= act_nxt;
      rpt_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    act_nxt   = act_dir;
    cnt_nxt   = rpt_cnt;
    rpt_vld   = 1'b0;
    case (state)
      IDLE: begin
        if (press_any && REPEAT_EN) begin
          state_nxt = ARMED;
          act_nxt   = press_dir;
          cnt_nxt   = DELAY_LD;
        end
      end
      ARMED: begin
        if (press_any) begin
          act_nxt = press_dir;
          cnt_nxt = DELAY_LD;
        end else if (!held[act_dir]) begin
          state_nxt = IDLE;
        end else if (frame_tick) begin
          if (rpt_cnt == CW'(1)) begin
            rpt_vld = 1'b1;
            cnt_nxt = RATE_LD;
          end else begin
            cnt_nxt = rpt_cnt - CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // a press in the same cycle silently shadows a repeat
  assign enq_vld = press_any | rpt_vld;
  assign enq_dat = press_any ? press_dir : act_dir;

  hop_fifo #(.W(2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .push_vld (enq_vld),
    .push_dat (enq_dat),
    .push_rdy (enq_rdy),
    .pop_vld  (hop_valid),
    .pop_dat  (hop_dir),
    .pop_rdy  (hop_ready)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_dir <= '0;
      overflow <= 1'b0;
    end else begin
      if (enq_vld && enq_rdy)  last_dir <= 4'b0001 << enq_dat;
      if (enq_vld && !enq_rdy) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hop_input_ctrl.sv
// Bench for hop_input_ctrl: decode vectors, directed hop/repeat/queue sequences and a randomized run
// checked every cycle against an event-level reference model.
module tb_hop_input_ctrl;
  localparam int DELAY = 15;
  localparam int RATE  = 6;
  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] keycode = '0;
  logic        frame_clk = 1'b0;
  logic        hop_ready = 1'b1;
  logic        hop_valid, hop_valid2;
  logic [1:0]  hop_dir, hop_dir2;
  logic [3:0]  held, held2, last_dir, last_dir2;
  logic        overflow, overflow2;

  hop_input_ctrl #(.NUM_SLOTS(2), .REPEAT_EN(1'b1), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE),
                   .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_clk(frame_clk), .hop_ready(hop_ready),
    .hop_valid(hop_valid), .hop_dir(hop_dir), .held(held), .last_dir(last_dir), .overflow(overflow));

  hop_input_ctrl #(.NUM_SLOTS(2), .REPEAT_EN(1'b0), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE),
                   .FIFO_DEPTH(DEPTH)) dut_norpt (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_clk(frame_clk), .hop_ready(hop_ready),
    .hop_valid(hop_valid2), .hop_dir(hop_dir2), .held(held2), .last_dir(last_dir2), .overflow(overflow2));

  always #5 Clk = ~Clk;

  int n_err = 0;
  int n_chk = 0;
  int popped[$];
  int n2 = 0;

  // reference model state
  int         m_q[$];
  logic [3:0] m_held, m_prev, m_last;
  logic       m_ovf;
  bit         fh[3];
  bit         m_armed;
  int         m_act, m_left;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] decode(input logic [15:0] kc);
    logic [3:0] h = '0;
    logic [7:0] s;
    for (int k = 0; k < 2; k++) begin
      s = kc[8*k +: 8];
      if (s == 8'h52) h[0] = 1'b1;
      if (s == 8'h51) h[1] = 1'b1;
      if (s == 8'h50) h[2] = 1'b1;
      if (s == 8'h4F) h[3] = 1'b1;
    end
    return h;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_held = '0; m_prev = '0; m_last = '0; m_ovf = 1'b0;
    fh[0] = 0; fh[1] = 0; fh[2] = 0;
    m_armed = 0; m_act = 0; m_left = 0;
  endtask

  // one clock edge of the model, using the inputs present at that edge
  task automatic model_step();
    logic [3:0] pr;
    bit tick, pop, ev;
    int dir;
    if (!Reset_n) begin
      model_reset();
    end else begin
      pr   = m_held & ~m_prev;
      tick = fh[1] && !fh[2];
      pop  = (m_q.size() != 0) && hop_ready;
      ev   = 0;
      dir  = 0;
      if (pr != 0) begin
        ev = 1;
        for (int i = 3; i >= 0; i--) if (pr[i]) dir = i;
        m_armed = 1; m_act = dir; m_left = DELAY;
      end else if (m_armed && !m_held[m_act]) begin
        m_armed = 0;
      end else if (m_armed && tick) begin
        m_left--;
        if (m_left == 0) begin
          ev = 1; dir = m_act; m_left = RATE;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (ev) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(dir);
          m_last = 4'b0001 << dir;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_prev = m_held;
      m_held = decode(keycode);
      fh[2] = fh[1]; fh[1] = fh[0]; fh[0] = frame_clk;
    end
  endtask

  task automatic model_check();
    chk("m_valid", {31'b0, hop_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) chk("m_dir", {30'b0, hop_dir}, m_q[0]);
    chk("m_held", {28'b0, held}, {28'b0, m_held});
    chk("m_last", {28'b0, last_dir}, {28'b0, m_last});
    chk("m_ovf", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  task automatic cyc();
    if (hop_valid && hop_ready) popped.push_back(int'(hop_dir));
    if (hop_valid2 && hop_ready) n2++;
    @(posedge Clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1; cycn(4);
      frame_clk = 1'b0; cycn(4);
    end
  endtask

  task automatic tap(input logic [15:0] kc);
    keycode = kc; cycn(3);
    keycode = '0; cycn(3);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    model_reset();
    cycn(2);
    chk("rst_valid", {31'b0, hop_valid}, 32'd0);
    chk("rst_dir", {30'b0, hop_dir}, 32'd0);
    chk("rst_held", {28'b0, held}, 32'd0);
    chk("rst_last", {28'b0, last_dir}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    Reset_n = 1'b1;
    cyc();
  endtask

  typedef struct {
    logic [15:0] kc;
    logic [3:0]  exp_held;
  } vec_t;

  vec_t vecs[8];
  int bad;
  int fcnt;
  int rmode;

  function automatic logic [7:0] rnd_slot();
    case ($urandom_range(0, 6))
      0, 1:    return 8'h00;
      2:       return 8'h52;
      3:       return 8'h51;
      4:       return 8'h50;
      5:       return 8'h4F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    vecs[0] = '{16'h0052, 4'b0001};
    vecs[1] = '{16'h5100, 4'b0010};
    vecs[2] = '{16'h5051, 4'b0110};
    vecs[3] = '{16'h4F00, 4'b1000};
    vecs[4] = '{16'h0000, 4'b0000};
    vecs[5] = '{16'h5252, 4'b0001};
    vecs[6] = '{16'h1234, 4'b0000};
    vecs[7] = '{16'h4F52, 4'b1001};

    hop_ready = 1'b1;
    do_reset();

    // single press: hop_valid two edges after the keycode change, exactly one hop
    popped.delete();
    keycode = 16'h0052;
    cyc();
    chk("sp_held", {28'b0, held}, 32'h1);
    chk("sp_early", {31'b0, hop_valid}, 32'd0);
    cyc();
    chk("sp_valid", {31'b0, hop_valid}, 32'd1);
    chk("sp_dir", {30'b0, hop_dir}, 32'd0);
    cycn(98);
    chk("sp_count", popped.size(), 32'd1);
    chk("sp_last", {28'b0, last_dir}, 32'h1);
    keycode = '0; cycn(3);

    // decode table
    for (int i = 0; i < 8; i++) begin
      keycode = vecs[i].kc;
      cyc();
      chk($sformatf("dec%0d", i), {28'b0, held}, {28'b0, vecs[i].exp_held});
    end
    keycode = '0; cycn(5);

    // auto-repeat: 40 frames held gives press + ticks 15,21,27,33,39
    popped.delete(); n2 = 0;
    keycode = 16'h004F; cycn(2);
    frames(40);
    chk("ar_count", popped.size(), 32'd6);
    bad = 0;
    foreach (popped[i]) if (popped[i] != 3) bad++;
    chk("ar_dirs", bad, 32'd0);
    chk("ar_norpt_count", n2, 32'd1);
    keycode = '0; popped.delete(); n2 = 0;
    cyc();
    frames(20);
    chk("ar_stop", popped.size(), 32'd0);

    // slot priority: down beats left; left left held never repeats
    popped.delete();
    keycode = 16'h5051;
    cyc();
    chk("pr_held", {28'b0, held}, 32'h6);
    cycn(9);
    chk("pr_count", popped.size(), 32'd1);
    if (popped.size() > 0) chk("pr_dir", popped[0], 32'd1);
    keycode = 16'h5000; popped.delete();
    cyc();
    chk("pr_held2", {28'b0, held}, 32'h4);
    frames(20);
    chk("pr_norpt", popped.size(), 32'd0);
    keycode = '0; cycn(3);

    // overflow: five presses into a depth-4 queue with no consumer
    hop_ready = 1'b0; popped.delete(); n2 = 0;
    tap(16'h0052); tap(16'h0051); tap(16'h0050); tap(16'h004F); tap(16'h0052);
    chk("ov_valid", {31'b0, hop_valid}, 32'd1);
    chk("ov_flag", {31'b0, overflow}, 32'd1);
    chk("ov_flag2", {31'b0, overflow2}, 32'd1);
    hop_ready = 1'b1;
    cycn(8);
    chk("ov_count", popped.size(), 32'd4);
    bad = 0;
    foreach (popped[i]) if (popped[i] != i) bad++;
    chk("ov_order", bad, 32'd0);
    chk("ov_count2", n2, 32'd4);
    chk("ov_sticky", {31'b0, overflow}, 32'd1);

    // full queue with a pop on the enqueue edge
    do_reset();
    hop_ready = 1'b0; popped.delete();
    tap(16'h0052); tap(16'h0051); tap(16'h0050); tap(16'h004F);
    keycode = 16'h0052;
    cyc();
    hop_ready = 1'b1;
    cyc();
    hop_ready = 1'b0;
    chk("fp_ovf", {31'b0, overflow}, 32'd0);
    chk("fp_head", {30'b0, hop_dir}, 32'd1);
    keycode = '0; cycn(3);
    hop_ready = 1'b1;
    cycn(8);
    chk("fp_count", popped.size(), 32'd5);
    if (popped.size() == 5) chk("fp_tail", popped[4], 32'd0);
    chk("fp_ovf_end", {31'b0, overflow}, 32'd0);

    // asynchronous reset while armed with two entries queued
    hop_ready = 1'b0; popped.delete();
    keycode = 16'h004F; cycn(3);
    frames(15);
    chk("rs_pre", {31'b0, hop_valid}, 32'd1);
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    chk("rs_valid", {31'b0, hop_valid}, 32'd0);
    chk("rs_held", {28'b0, held}, 32'd0);
    chk("rs_last", {28'b0, last_dir}, 32'd0);
    chk("rs_ovf", {31'b0, overflow}, 32'd0);
    cycn(2);
    #3 Reset_n = 1'b1;
    hop_ready = 1'b1; popped.delete();
    cycn(40);
    chk("rs_count", popped.size(), 32'd1);
    if (popped.size() > 0) chk("rs_dir", popped[0], 32'd3);
    keycode = '0; cycn(3);

    // randomized run against the model
    do_reset();
    fcnt = 3; rmode = 0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 149) == 0) keycode = {rnd_slot(), rnd_slot()};
      if (fcnt == 0) begin
        frame_clk = ~frame_clk;
        fcnt = $urandom_range(2, 8);
      end else begin
        fcnt--;
      end
      if ($urandom_range(0, 49) == 0) rmode = $urandom_range(0, 2);
      hop_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/hop_input_ctrl.md
# hop_input_ctrl

Parametrised keyboard front end for the frog game: converts the multi-slot USB keycode word from the NIOS keycode PIO into a queue of discrete hop commands with press-edge detection, frame-paced auto-repeat and a valid/ready handshake toward the frog motion logic. It sits between the `nios_system` keycode export and `frog`. It replaces the level-decoded `up/down/left/right` wires and the sticky last-key register that drives LEDG.

## Interface
Parameters:
- `NUM_SLOTS`, 2: number of 8-bit keycode slots in `keycode`.
- `KEY_UP`, 8'h52; `KEY_DOWN`, 8'h51; `KEY_LEFT`, 8'h50; `KEY_RIGHT`, 8'h4F: direction keycodes. Must be nonzero and distinct.
- `REPEAT_EN`, 1: 1 = auto-repeat while held, 0 = one hop per press.
- `REPEAT_DELAY`, 15: frames from press to first repeat. Must be ≥1.
- `REPEAT_RATE`, 6: frames between subsequent repeats. Must be ≥1.
- `FIFO_DEPTH`, 4: hop queue depth. Power of two, ≥2.

Ports:
- `Clk` in 1: system clock (CLOCK_50).
- `Reset_n` in 1: asynchronous, active-low reset.
- `keycode` in 8*NUM_SLOTS: keycode slots, synchronous to `Clk`. Slot k is bits [8k+7:8k]; 8'h00 = empty slot.
- `frame_clk` in 1: VGA vsync. Asynchronous to `Clk`.
- `hop_ready` in 1: consumer accepts the head entry.
- `hop_valid` out 1: queue non-empty.
- `hop_dir` out 2: head direction. 0 = up, 1 = down, 2 = left, 3 = right.
- `held` out 4: registered held mask, bit index = direction code.
- `last_dir` out 4: one-hot of the most recently enqueued direction (LEDG).
- `overflow` out 1: sticky; an event was dropped because the queue was full.

## Operation
- **Decode:** `held_raw[d]` = OR over slots of (slot == KEY_d). Empty slots never match. `held` registers `held_raw` every cycle; `held_q` registers `held`.
- **Frame tick:** `frame_clk` passes through a 2-flop synchroniser plus an edge flop. `frame_tick` is a one-cycle pulse on the synchronised rising edge.
- **Press event:** `press[d] = held[d] & ~held_q[d]`.
  - If several bits are set in one cycle, only the highest priority direction is enqueued, in the order up > down > left > right. The others are discarded and `overflow` is not set.
- **Repeat FSM**, states IDLE and ARMED, with registers `act_dir` and `rpt_cnt`:
  - IDLE → ARMED on any press. `act_dir` is loaded with the enqueued direction and `rpt_cnt` with REPEAT_DELAY.
  - ARMED, press of a different direction: retarget. `act_dir` is reloaded and `rpt_cnt` = REPEAT_DELAY.
  - ARMED, `held[act_dir]` = 0: → IDLE. Any other still-held key does not repeat until it is pressed again.
  - ARMED with `frame_tick`: `rpt_cnt` decrements. On the tick where `rpt_cnt` is 1, if REPEAT_EN, a repeat event for `act_dir` is raised and `rpt_cnt` reloads to REPEAT_RATE.
  - If REPEAT_EN = 0, the FSM never leaves IDLE.
- **Event arbitration:** at most one enqueue per cycle. A press event wins over a repeat event in the same cycle; the repeat is dropped silently.
- **Queue:** synchronous FIFO, first-word fall-through.
  - `hop_valid` = !empty and `hop_dir` = head entry.
  - Pop when `hop_valid & hop_ready`.
  - When full, enqueue is refused unless a pop occurs in the same cycle; simultaneous push+pop at full is accepted.
  - A refused enqueue sets `overflow`. It clears only on reset.
  - `last_dir` updates only on an accepted enqueue.
- **Widths:**
  - Counter width = $clog2(max(REPEAT_DELAY, REPEAT_RATE) + 1).
  - FIFO pointers are $clog2(FIFO_DEPTH) + 1 bits, using the wrap-bit full/empty scheme.

## Timing
- **Reset values:** on `Reset_n` low, all state clears immediately. `hop_valid` = 0, `hop_dir` = 0, `held` = 0, `last_dir` = 0, `overflow` = 0, FSM = IDLE, FIFO empty, synchroniser flops = 0. Deassertion mid-hold counts as a new press on the first cycle after reset (`held_q` = 0).
- **Press latency:** `keycode` changes before edge t. `held` is set at t, the press is enqueued at t+1, and `hop_valid` is high after edge t+1. That is 2 cycles.
- **Frame latency:** `frame_tick` occurs 3 `Clk` edges after the `frame_clk` rise.
- **Repeat spacing:**
  - First repeat on the REPEAT_DELAY-th `frame_tick` after the press.
  - Subsequent repeats every REPEAT_RATE ticks.
  - The repeat is enqueued the cycle after its tick.
- **Handshake:** `hop_dir` is stable while `hop_valid` = 1 and `hop_ready` = 0. Back-to-back pops at one per cycle are supported.

## Test plan
- **Single press:** reset, `keycode` = 16'h0052 for 100 cycles with `hop_ready` = 1 → exactly one `hop_valid` pulse with `hop_dir` = 0, arriving 2 cycles after the change; `held` = 4'b0001; `last_dir` = 4'b0001.
- **Auto-repeat:** hold 16'h004F for 40 frames with REPEAT_DELAY = 15 and REPEAT_RATE = 6 → hops with dir 3 at press, tick 15, 21, 27, 33 and 39. Total 6. Stops within 1 cycle of release.
- **Slot/priority:** `keycode` goes 0 → 16'h5051 in one cycle → one hop with dir 1 (down beats left). Then clear slot 0 only (16'h5000) → no new hop; the FSM goes to IDLE when down releases, and left does not repeat.
- **Overflow:** `hop_ready` = 0, REPEAT_EN = 0, FIFO_DEPTH = 4, five distinct press/release pairs → `hop_valid` stays high, the first 4 dirs are popped in order once `hop_ready` = 1, the 5th is lost, and `overflow` = 1 until reset.
- **Full push+pop:** FIFO full with `hop_ready` = 1 and a press in the same cycle → the entry is accepted, `overflow` stays 0 and the count stays 4.
- **Async reset mid-repeat:** assert `Reset_n` = 0 between `Clk` edges while ARMED with 2 entries queued → `hop_valid`, `held`, `last_dir` and `overflow` go 0 before the next edge. After release with the key still held, one new hop is produced.
